cordic_atanh_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC inverse-hyperbolic-tangent core among N_REQ requesters. It accepts one operand per cycle through per-requester valid/ready handshakes and range-checks each operand. In-range operands go to the core. Each result is routed back to its originating requester, with completion tracked by a tag pipeline aligned to the core latency. The block sits between the requesting units and the core: it drives the core input and observes the core output, and it does not instantiate the core.

---
 rtl/cordic_atanh_scheduler.sv | 140 ++++++++++++++
 tb/tb_cordic_atanh_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atanh_scheduler.sv
// Round-robin front end for a shared pipelined CORDIC atanh core.
// The core is outside this block. This block arbitrates requester operands
// and range-checks them before issue. A tag pipeline aligned to the core
// latency routes each core result back to the requester that issued it.
module cordic_atanh_scheduler #(
    parameter int N_REQ    = 4,
    parameter int CORE_LAT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [20*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      res_valid,
    output logic [20*N_REQ-1:0]   res_z,
    output logic [N_REQ-1:0]      res_err,
    input  logic [N_REQ-1:0]      res_ready,
    output logic [19:0]           core_y,
    input  logic [19:0]           core_z
);

    localparam int          IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR   = N_REQ;

    logic [N_REQ-1:0]    busy_q, busy_d;
    logic [IDXW-1:0]     rr_q, rr_d;
    logic [19:0]         core_y_q, core_y_d;
    logic [N_REQ-1:0]    res_valid_q, res_valid_d;
    logic [20*N_REQ-1:0] res_z_q, res_z_d;
    logic [N_REQ-1:0]    res_err_q, res_err_d;

    logic [CORE_LAT:0]   tag_v_q;
    logic [CORE_LAT:0]   tag_err_q;
    logic [IDXW-1:0]     tag_idx_q [CORE_LAT+1];

    logic                grant_vld;
    logic [IDXW-1:0]     grant_idx;
    logic [IDXW-1:0]     cand;
    logic [19:0]         acc_y;
    logic                acc_err;
    logic [N_REQ-1:0]    consume;
    logic [IDXW-1:0]     ret_idx;
    logic                ret_err;

    // Round-robin pick: first requester that is valid and not busy, scanning from rr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NR; off++) begin
            cand = IDXW'((32'(rr_q) + off) % NR);
            if (!grant_vld && req_valid[cand] && !busy_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot grant. It is forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (grant_vld && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Select the accepted operand and check it lies strictly inside (-1.0, 1.0).
    always_comb begin
        acc_y   = req_y[20*grant_idx +: 20];
        acc_err = !(($signed(acc_y) >= -20'sd65535) && ($signed(acc_y) <= 20'sd65535));
    end

    assign ret_idx = tag_idx_q[CORE_LAT];
    assign ret_err = tag_err_q[CORE_LAT];

    // Next state for the busy flags, the rr pointer, the issue register and the result slots.
    always_comb begin
        consume     = res_valid_q & res_ready;
        busy_d      = busy_q & ~consume;
        res_valid_d = res_valid_q & ~consume;
        rr_d        = rr_q;
        core_y_d    = '0;
        res_z_d     = res_z_q;
        res_err_d   = res_err_q;
        if (grant_vld) begin
            busy_d[grant_idx] = 1'b1;
            rr_d              = (grant_idx == IDXW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            core_y_d          = acc_err ? '0 : acc_y;
        end
        // A retiring slot is never valid here, because busy blocks a new accept until consume.
        if (tag_v_q[CORE_LAT]) begin
            res_valid_d[ret_idx]         = 1'b1;
            res_err_d[ret_idx]           = ret_err;
            res_z_d[20*ret_idx +: 20]    = ret_err ? '0 : core_z;
        end
    end

    // State registers for arbitration, issue and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            rr_q        <= '0;
            core_y_q    <= '0;
            res_valid_q <= '0;
            res_z_q     <= '0;
            res_err_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            rr_q        <= rr_d;
            core_y_q    <= core_y_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_err_q   <= res_err_d;
        end
    end

    // Tag pipeline. Stage 0 lines up with core_y and the last stage lines up with core_z.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_q   <= '0;
            tag_err_q <= '0;
            for (int unsigned s = 0; s <= CORE_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            tag_v_q      <= {tag_v_q[CORE_LAT-1:0], grant_vld};
            tag_err_q    <= {tag_err_q[CORE_LAT-1:0], grant_vld & acc_err};
            tag_idx_q[0] <= grant_idx;
            for (int unsigned s = 1; s <= CORE_LAT; s++) begin
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign core_y    = core_y_q;
    assign res_valid = res_valid_q;
    assign res_z     = res_z_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_cordic_atanh_scheduler.sv
// Directed bench for cordic_atanh_scheduler with a behavioural atanh core model.
module tb_cordic_atanh_scheduler;

    localparam int N   = 4;
    localparam int LAT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, res_valid, res_err, res_ready;
    logic [20*N-1:0] req_y, res_z;
    logic [19:0]     core_y, core_z;
    logic [19:0]     cpipe [LAT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          r;
        logic [19:0] y;
        logic        err;
        logic [19:0] cy;
    } vec_t;

    vec_t vecs [8];

    cordic_atanh_scheduler #(.N_REQ(N), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_y(req_y), .req_ready(req_ready),
        .res_valid(res_valid), .res_z(res_z), .res_err(res_err), .res_ready(res_ready),
        .core_y(core_y), .core_z(core_z)
    );

    always #5 clk = ~clk;

    // atanh of a Q4.16 operand, returned in Q6.14 format.
    function automatic logic [19:0] core_fn(input logic [19:0] y);
        int  yi;
        real r, z;
        yi = int'($signed(y));
        r  = real'(yi) / 65536.0;
        if (r >= 1.0 || r <= -1.0) return '0;
        z = 0.5 * $ln((1.0 + r) / (1.0 - r));
        return 20'($rtoi(z * 16384.0));
    endfunction

    initial for (int i = 0; i < LAT; i++) cpipe[i] = '0;

    always @(posedge clk) begin
        cpipe[0] <= core_y;
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_z = core_fn(cpipe[LAT-1]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic [19:0] ez;
        ez = v.err ? 20'h0 : core_fn(v.cy);
        req_y[20*v.r +: 20] = v.y;
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        #1;
        chk("vec_ready", 32'(req_ready), 32'(1) << v.r);
        cyc();
        req_valid = '0;
        #1;
        chk("vec_core_y", 32'(core_y), 32'(v.cy));
        n = 1;
        while (res_valid[v.r] !== 1'b1 && n < LAT + 10) begin
            cyc();
            #1;
            n++;
        end
        chk("vec_latency", n, LAT + 2);
        chk("vec_res_z", 32'(res_z[20*v.r +: 20]), 32'(ez));
        chk("vec_res_err", 32'(res_err[v.r]), 32'(v.err));
        cyc();
        res_ready[v.r] = 1'b1;
        cyc();
        res_ready = '0;
        #1;
        chk("vec_consumed", 32'(res_valid), 32'(0));
    endtask

    logic [19:0] ops [N];
    int n, acc, c0, c1;

    initial begin
        vecs[0] = '{0, 20'h0778D, 1'b0, 20'h0778D};
        vecs[1] = '{1, 20'h0FFFF, 1'b0, 20'h0FFFF};
        vecs[2] = '{2, 20'hF0001, 1'b0, 20'hF0001};
        vecs[3] = '{3, 20'h10000, 1'b1, 20'h00000};
        vecs[4] = '{0, 20'hF0000, 1'b1, 20'h00000};
        vecs[5] = '{1, 20'h00000, 1'b0, 20'h00000};
        vecs[6] = '{2, 20'h80000, 1'b1, 20'h00000};
        vecs[7] = '{3, 20'hF8873, 1'b0, 20'hF8873};

        // Reset state, with requests already presented.
        rst = 1'b1;
        req_y = '0;
        res_ready = '0;
        req_valid = '1;
        cyc();
        cyc();
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_res_z", 32'(|res_z), 0);
        chk("rst_core_y", 32'(core_y), 0);
        cyc();
        req_valid = '0;
        rst = 1'b0;
        cyc();

        // Single requests, including the range boundaries.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            cyc();
        end

        // Contention: all four requesters valid from reset.
        ops[0] = 20'h0778D; ops[1] = 20'hF8873; ops[2] = 20'h0E666; ops[3] = 20'h0CCCC;
        do_reset();
        for (int i = 0; i < N; i++) req_y[20*i +: 20] = ops[i];
        req_valid = '1;
        #1;
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                cyc();
                #1;
            end
            chk("cont_grant", 32'(req_ready), 32'(1) << i);
        end
        cyc();
        #1;
        chk("cont_all_busy", 32'(req_ready), 0);
        n = 0;
        while (res_valid == '0 && n < 40) begin
            cyc();
            #1;
            n++;
        end
        chk("cont_first_ret", n, LAT - 2);
        for (int i = 0; i < N; i++) begin
            chk("cont_order", 32'(res_valid), (32'(2) << i) - 1);
            chk("cont_res_z", 32'(res_z[20*i +: 20]), 32'(core_fn(ops[i])));
            if (i < N - 1) begin
                cyc();
                #1;
            end
        end

        // Backpressure on requester 2 while requesters 0, 1 and 3 keep cycling.
        cyc();
        res_ready = 4'b1011;
        req_valid = 4'b1111;
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            #1;
            chk("bp_rv2", 32'(res_valid[2]), 1);
            chk("bp_z2", 32'(res_z[40 +: 20]), 32'(core_fn(ops[2])));
            chk("bp_ready2", 32'(req_ready[2]), 0);
            acc += $countones(req_valid & req_ready);
        end
        chk("bp_others_serviced", 32'(acc >= 6), 1);
        cyc();
        req_valid = 4'b0100;
        res_ready = 4'b0100;
        #1;
        chk("bp_no_same_cycle", 32'(req_ready[2]), 0);
        cyc();
        res_ready = '0;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'(4'b0100));
        chk("bp_rv2_clear", 32'(res_valid[2]), 0);
        cyc();
        req_valid = '0;

        // Fairness between two always-valid requesters.
        do_reset();
        req_y[0 +: 20]  = 20'h0778D;
        req_y[20 +: 20] = 20'h0CCCC;
        req_valid = 4'b0011;
        res_ready = 4'b0011;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_valid[0] && req_ready[0]) c0++;
            if (req_valid[1] && req_ready[1]) c1++;
            cyc();
        end
        chk("fair_diff", 32'((c0 - c1 <= 1) && (c1 - c0 <= 1)), 1);
        chk("fair_progress", 32'(c0 >= 8), 1);

        // Asynchronous reset with operations in flight.
        ops[1] = 20'hF0000;
        do_reset();
        for (int i = 0; i < N; i++) req_y[20*i +: 20] = ops[i];
        req_valid = '1;
        res_ready = '1;
        repeat (20) cyc();
        #1;
        chk("pre_rst_rv", 32'(res_valid), 32'(4'b0100));
        chk("pre_rst_err", 32'(res_err), 32'(4'b0010));
        chk("pre_rst_core_y", 32'(core_y), 32'(ops[0]));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 0);
        chk("arst_res_valid", 32'(res_valid), 0);
        chk("arst_res_err", 32'(res_err), 0);
        chk("arst_res_z", 32'(|res_z), 0);
        chk("arst_core_y", 32'(core_y), 0);
        req_valid = '0;
        res_ready = '0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc();
            #1;
            chk("post_rst_quiet", 32'(res_valid), 0);
        end
        cyc();
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
